// File: rtl/imm_extend_pipe_pkg.sv
// Shared types for the immediate-extension pipe: extension modes and skid-buffer FSM states.
package imm_ext_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned STATE_W = 2;

    typedef logic [MODE_W-1:0] imm_mode_t;

    localparam imm_mode_t MODE_SIGN   = 2'b00;
    localparam imm_mode_t MODE_ZERO   = 2'b01;
    localparam imm_mode_t MODE_UPPER  = 2'b10;
    localparam imm_mode_t MODE_BRANCH = 2'b11;

    typedef logic [STATE_W-1:0] skid_state_t;

    localparam skid_state_t ST_EMPTY = 2'd0;
    localparam skid_state_t ST_ONE   = 2'd1;
    localparam skid_state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bus around the immediate-extension pipe: upstream immediate in, extended immediate out.
interface imm_extend_pipe_if
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) ();

    logic             valid_i;
    logic             ready_o;
    imm_mode_t        mode_i;
    logic [IN_W-1:0]  data_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [OUT_W-1:0] data_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output valid_i, mode_i, data_i, tag_i, ready_i,
        input  ready_o, valid_o, data_o, tag_o
    );

    modport slave (
        input  valid_i, mode_i, data_i, tag_i, ready_i,
        output ready_o, valid_o, data_o, tag_o
    );

endinterface

// File: rtl/imm_extend_pipe_core.sv
// Combinational immediate widening (sign/zero/upper/branch).
// IMM_EXT_BRANCH_EN enables the branch-offset shifter; otherwise mode 11 decodes as sign.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  imm_mode_t        i_mode,
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_result_c
);

    localparam int unsigned UPPER_SHIFT = OUT_W - IN_W;

    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_zero;
    logic [OUT_W-1:0] w_upper;

    assign w_sign  = OUT_W'($signed(i_data));
    assign w_zero  = OUT_W'(i_data);
    // Shift by zero degenerates to pass-through when IN_W == OUT_W.
    assign w_upper = w_zero << UPPER_SHIFT;

`ifdef IMM_EXT_BRANCH_EN
    logic [OUT_W-1:0] w_branch;
    assign w_branch = w_sign << 2;
`endif

    always_comb begin
        o_result_c = w_sign;
        case (i_mode)
            MODE_ZERO:   o_result_c = w_zero;
            MODE_UPPER:  o_result_c = w_upper;
`ifdef IMM_EXT_BRANCH_EN
            MODE_BRANCH: o_result_c = w_branch;
`endif
            default:     o_result_c = w_sign;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a two-entry skid buffer (main + skid).
// Branch-offset mode is gated by IMM_EXT_BRANCH_EN inside imm_ext_core.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic             clk_i,
    input logic             rst_i,
    imm_extend_pipe_if.slave bus
);

    skid_state_t      r_state;
    skid_state_t      w_state_nxt;
    logic             r_valid;
    logic             r_ready;
    logic [OUT_W-1:0] r_main_data;
    logic [TAG_W-1:0] r_main_tag;
    logic [OUT_W-1:0] r_skid_data;
    logic [TAG_W-1:0] r_skid_tag;

    logic             w_accept;
    logic             w_retire;
    logic             w_main_new;
    logic             w_main_skid;
    logic             w_skid_new;
    logic [OUT_W-1:0] w_ext;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_mode     (bus.mode_i),
        .i_data     (bus.data_i),
        .o_result_c (w_ext)
    );

    assign w_accept = bus.valid_i && r_ready;
    assign w_retire = r_valid && bus.ready_i;

    // Next state and register load strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_main_new  = 1'b0;
        w_main_skid = 1'b0;
        w_skid_new  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_main_new  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_retire) begin
                    w_main_new  = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_TWO;
                    w_skid_new  = 1'b1;
                end else if (w_retire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_retire) begin
                    w_state_nxt = ST_ONE;
                    w_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state so no input reaches an output.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt != ST_EMPTY);
            r_ready <= (w_state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_main_data <= '0;
            r_main_tag  <= '0;
            r_skid_data <= '0;
            r_skid_tag  <= '0;
        end else begin
            if (w_main_new) begin
                r_main_data <= w_ext;
                r_main_tag  <= bus.tag_i;
            end else if (w_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_tag  <= r_skid_tag;
            end
            if (w_skid_new) begin
                r_skid_data <= w_ext;
                r_skid_tag  <= bus.tag_i;
            end
        end
    end

    assign bus.ready_o = r_ready;
    assign bus.valid_o = r_valid;
    assign bus.data_o  = r_main_data;
    assign bus.tag_o   = r_main_tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: queue-based reference model plus directed literal vectors.
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus_a ();
    imm_extend_pipe_if #(.IN_W(8),  .OUT_W(8),  .TAG_W(5)) bus_b ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(8), .TAG_W(5)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

`ifdef IMM_EXT_BRANCH_EN
    localparam logic [63:0] BRANCH_FFFF = 64'hFFFF_FFFC;
`else
    localparam logic [63:0] BRANCH_FFFF = 64'hFFFF_FFFF;
`endif

    typedef struct {
        longint data;
        int     tag;
    } exp_t;

    exp_t q[$];
    int   retired[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Extension rules written as plain arithmetic on unsigned values.
    function automatic longint ext_model(input int in_w, input int out_w, input int mode, input longint d);
        longint mod_out = longint'(1) << out_w;
        longint s = (d >= (longint'(1) << (in_w - 1))) ? d + mod_out - (longint'(1) << in_w) : d;
        case (mode)
            0:       return s;
            1:       return d;
            2:       return (d * (longint'(1) << (out_w - in_w))) % mod_out;
`ifdef IMM_EXT_BRANCH_EN
            default: return (s * 4) % mod_out;
`else
            default: return s;
`endif
        endcase
    endfunction

    // Per-cycle compare of dut_a against the FIFO model; handshakes sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
        end else begin
            check("valid_o", 64'(bus_a.valid_o), 64'(q.size() != 0));
            check("ready_o", 64'(bus_a.ready_o), 64'(q.size() < 2));
            if (q.size() != 0) begin
                check("data_o", 64'(bus_a.data_o), 64'(q[0].data));
                check("tag_o",  64'(bus_a.tag_o),  64'(q[0].tag));
            end
            if (bus_a.valid_o && bus_a.ready_i) begin
                retired.push_back(int'(bus_a.tag_o));
                if (q.size() != 0) void'(q.pop_front());
            end
            if (bus_a.valid_i && bus_a.ready_o)
                q.push_back('{ext_model(16, 32, int'(bus_a.mode_i), longint'(bus_a.data_i)),
                              int'(bus_a.tag_i)});
        end
    end

    task automatic send_a(input logic [15:0] d, input imm_mode_t m, input logic [4:0] t);
        bus_a.valid_i = 1'b1;
        bus_a.data_i  = d;
        bus_a.mode_i  = m;
        bus_a.tag_i   = t;
        @(posedge clk);
        #1;
        bus_a.valid_i = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input imm_mode_t m);
        bus_b.valid_i = 1'b1;
        bus_b.data_i  = d;
        bus_b.mode_i  = m;
        bus_b.tag_i   = 5'd3;
        @(posedge clk);
        #1;
        bus_b.valid_i = 1'b0;
    endtask

    // Continuous-valid stream; either a 3-cycle stall after the 2nd accept or ready_i toggling.
    task automatic stream(input int first_tag, input int n, input bit toggle);
        int acc_n = 0;
        int stall = 0;
        int cyc   = 0;
        bit acc;
        retired.delete();
        while (acc_n < n && cyc < 200) begin
            bus_a.valid_i = 1'b1;
            bus_a.data_i  = 16'h8421 ^ 16'(acc_n * 16'h0357);
            bus_a.mode_i  = imm_mode_t'(acc_n);
            bus_a.tag_i   = 5'(first_tag + acc_n);
            bus_a.ready_i = toggle ? cyc[0] : (stall == 0);
            acc = bus_a.ready_o;
            @(posedge clk);
            #1;
            cyc++;
            if (stall > 0) stall--;
            if (acc) begin
                acc_n++;
                if (!toggle && acc_n == 2) stall = 3;
                if (!toggle && acc_n == 3) check("skid_full_ready_o", 64'(bus_a.ready_o), 64'd0);
            end
        end
        check("stream_accepts", 64'(acc_n), 64'(n));
        bus_a.valid_i = 1'b0;
        bus_a.ready_i = 1'b1;
        cyc = 0;
        while (bus_a.valid_o && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_valid_o", 64'(bus_a.valid_o), 64'd0);
        check("retired_count", 64'(retired.size()), 64'(n));
        for (int i = 0; i < retired.size() && i < n; i++)
            check("retired_order", 64'(retired[i]), 64'(first_tag + i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_a.valid_i = 1'b0; bus_a.data_i = '0; bus_a.mode_i = MODE_SIGN;
        bus_a.tag_i   = '0;   bus_a.ready_i = 1'b1;
        bus_b.valid_i = 1'b0; bus_b.data_i = '0; bus_b.mode_i = MODE_SIGN;
        bus_b.tag_i   = '0;   bus_b.ready_i = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_o", 64'(bus_a.valid_o), 64'd0);
        check("rst_ready_o", 64'(bus_a.ready_o), 64'd1);
        check("rst_data_o",  64'(bus_a.data_o),  64'd0);
        check("rst_tag_o",   64'(bus_a.tag_o),   64'd0);
        check("rst_b_valid_o", 64'(bus_b.valid_o), 64'd0);
        rst = 1'b1;

        send_a(16'h8000, MODE_SIGN, 5'd1);
        check("sign_8000", 64'(bus_a.data_o), 64'hFFFF_8000);
        check("sign_tag",  64'(bus_a.tag_o),  64'd1);
        send_a(16'h8000, MODE_ZERO, 5'd2);
        check("zero_8000", 64'(bus_a.data_o), 64'h0000_8000);
        send_a(16'h8000, MODE_UPPER, 5'd3);
        check("upper_8000", 64'(bus_a.data_o), 64'h8000_0000);
        send_a(16'h1234, MODE_UPPER, 5'd4);
        check("upper_1234", 64'(bus_a.data_o), 64'h1234_0000);
        check("upper_tag",  64'(bus_a.tag_o),  64'd4);
        send_a(16'hFFFF, MODE_BRANCH, 5'd5);
        check("branch_ffff", 64'(bus_a.data_o), BRANCH_FFFF);
        @(posedge clk);
        #1;

        send_b(8'h80, MODE_SIGN);
        check("w8_sign",  64'(bus_b.data_o), 64'h80);
        send_b(8'h80, MODE_ZERO);
        check("w8_zero",  64'(bus_b.data_o), 64'h80);
        send_b(8'h80, MODE_UPPER);
        check("w8_upper", 64'(bus_b.data_o), 64'h80);

        stream(1, 8, 1'b0);
        stream(9, 12, 1'b1);

        // Fill main and skid, then reset mid-cycle.
        bus_a.ready_i = 1'b0;
        send_a(16'h00AA, MODE_ZERO, 5'd21);
        send_a(16'h00BB, MODE_ZERO, 5'd22);
        check("two_ready_o", 64'(bus_a.ready_o), 64'd0);
        check("two_valid_o", 64'(bus_a.valid_o), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid_o", 64'(bus_a.valid_o), 64'd0);
        check("arst_ready_o", 64'(bus_a.ready_o), 64'd1);
        check("arst_data_o",  64'(bus_a.data_o),  64'd0);
        check("arst_tag_o",   64'(bus_a.tag_o),   64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus_a.ready_i = 1'b1;
        send_a(16'h0001, MODE_ZERO, 5'd7);
        check("post_rst_data", 64'(bus_a.data_o), 64'h0000_0001);
        check("post_rst_tag",  64'(bus_a.tag_o),  64'd7);
        repeat (3) @(posedge clk);
        #1;
        check("final_idle_valid_o", 64'(bus_a.valid_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension stage for the CPU datapath: widens an IN_W-bit immediate to OUT_W bits in one of four selectable modes (sign, zero, upper-load, branch-offset) and registers the result. Sits between instruction decode and the ALU/branch-target logic. Carries a valid/ready handshake with a two-entry skid buffer, so it can stall without combinational ready paths. A sideband tag travels with each immediate.

## Interface
- IN_W, 16, immediate input width; legal range 1 ≤ IN_W ≤ OUT_W
- OUT_W, 32, extended output width
- TAG_W, 5, sideband tag width (e.g. destination register index); legal range TAG_W ≥ 1
- clk_i  in  1  clock, rising-edge
- rst_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  input immediate valid
- ready_o  out  1  stage can accept; registered
- mode_i  in  2  00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH
- data_i  in  IN_W  raw immediate
- tag_i  in  TAG_W  sideband tag
- valid_o  out  1  output valid
- ready_i  in  1  downstream accepts
- data_o  out  OUT_W  extended immediate
- tag_o  out  TAG_W  tag of the entry on data_o

## Operation
- Accept when valid_i && ready_o. Retire when valid_o && ready_i.
- Extension per accepted entry, computed at accept time:
  - SIGN: {(OUT_W-IN_W){data_i[IN_W-1]}, data_i}
  - ZERO: {(OUT_W-IN_W){1'b0}, data_i}
  - UPPER: {data_i, (OUT_W-IN_W){1'b0}}; if IN_W == OUT_W, data_i unchanged
  - BRANCH: SIGN result shifted left 2, low 2 bits zero, top 2 bits discarded
- Storage: main register (drives data_o/tag_o) plus one skid register.
- FSM states: EMPTY, ONE (main full), TWO (main and skid full).
  - EMPTY: accept → ONE, main ← new.
  - ONE: accept && retire → ONE, main ← new. Accept only → TWO, skid ← new. Retire only → EMPTY.
  - TWO: ready_o = 0, no accept. Retire → ONE, main ← skid.
- valid_o = (state != EMPTY). ready_o = (state != TWO).
- Order is strict FIFO; no entry is dropped or duplicated.
- Data fields of empty registers hold their last value; they are not cleared.

## Timing
- Latency: 1 cycle. An entry accepted at edge N appears on data_o after edge N when the stage was EMPTY, or when the stage was ONE and retired at the same edge.
- Throughput: 1 entry/cycle while ready_i = 1.
- No combinational path from any input to any output. All outputs are registered.
- Reset values: valid_o = 0, ready_o = 1, data_o = 0, tag_o = 0. State returns to EMPTY; skid contents are cleared to 0.
- Reset asserted mid-operation: all entries are discarded immediately, asynchronously. The first accept is possible on the first rising edge after rst_i deasserts.
- Mode is sampled with the data at accept. Changing mode_i while an entry is held has no effect on that entry.

## Configuration
- IMM_EXT_BRANCH_EN defined: mode 11 performs BRANCH extension as specified.
- IMM_EXT_BRANCH_EN undefined: mode 11 is decoded as SIGN, and the shifter logic is not synthesised.

## Structure
- Package imm_ext_pkg holds:
  - mode typedef imm_mode_t (2 bits) and constants MODE_SIGN, MODE_ZERO, MODE_UPPER, MODE_BRANCH
  - FSM state typedef skid_state_t (EMPTY/ONE/TWO)
- Sub-module imm_ext_core: purely combinational; mode + data_i → OUT_W result; parameters IN_W, OUT_W. The pipe instantiates one at its input.

## Test plan
- IN_W = 16, OUT_W = 32, ready_i = 1. Send data_i 0x8000 in SIGN, ZERO and UPPER, then 0x1234 in UPPER. Required data_o, each one cycle later: 0xFFFF8000, 0x00008000, 0x80000000, 0x12340000.
- IMM_EXT_BRANCH_EN defined: data_i 0xFFFF, mode 11 → data_o 0xFFFFFFFC. Macro undefined: same stimulus → 0xFFFFFFFF.
- Back-to-back stream with tags 1..8, ready_i held 0 for 3 cycles after the 2nd accept:
  - ready_o drops the cycle after the skid fills.
  - Outputs resume in order with tags 1..8, with no loss and no duplication.
- ready_i toggling every cycle under continuous valid_i: tag order is preserved, and valid_o never drops while entries are held.
- Assert rst_i low in state TWO: valid_o = 0, ready_o = 1 and data_o = 0 immediately. After release, a new entry 0x0001 in ZERO mode yields 0x00000001.
- IN_W = OUT_W = 8: data_i 0x80 → SIGN 0x80, ZERO 0x80, UPPER 0x80.
